// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the Booth multiplier.
// The BOOTH_RADIX4_EN macro (see booth_paso / booth_multiplicador) selects
// the radix-4 datapath; the digit encoding below serves that path.
package booth_pkg;

  // Default operand width in bits.
  localparam int N_DEF = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    OPERAR   = 2'd1,
    FIN      = 2'd2
  } estado_t;

  // Modified-Booth digit selected by {Q[1],Q[0],Q_1}.
  typedef enum logic [2:0] {
    DIG_0   = 3'd0,
    DIG_PM  = 3'd1,
    DIG_NM  = 3'd2,
    DIG_P2M = 3'd3,
    DIG_N2M = 3'd4
  } digito_t;

  // Recode a three-bit window into its radix-4 digit.
  function automatic digito_t booth_digit(input logic [2:0] bits);
    digito_t d;
    case (bits)
      3'b001, 3'b010: d = DIG_PM;
      3'b011:         d = DIG_P2M;
      3'b100:         d = DIG_N2M;
      3'b101, 3'b110: d = DIG_NM;
      default:        d = DIG_0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_paso.sv
// booth_paso: one combinational Booth iteration on {A,Q,Q_1} with multiplicand M.
// BOOTH_RADIX4_EN defined: radix-4 step (digits 0, +-M, +-2M, shift by 2).
// BOOTH_RADIX4_EN undefined: radix-2 step (0, +-M, shift by 1).
module booth_paso
  import booth_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = N + 1
) (
  input  logic [AW-1:0] i_a,
  input  logic [N-1:0]  i_q,
  input  logic          i_q1,
  input  logic [N-1:0]  i_m,
  output logic [AW-1:0] o_a,
  output logic [N-1:0]  o_q,
  output logic          o_q1
);

  logic [AW-1:0] w_m_ext;
  logic [AW-1:0] w_sum;

  assign w_m_ext = {{(AW-N){i_m[N-1]}}, i_m};

`ifdef BOOTH_RADIX4_EN
  digito_t w_dig;

  assign w_dig = booth_digit({i_q[1:0], i_q1});

  // Add the selected multiple of M, then arithmetic shift right by two.
  always_comb begin
    w_sum = i_a;
    case (w_dig)
      DIG_PM:  w_sum = i_a + w_m_ext;
      DIG_NM:  w_sum = i_a - w_m_ext;
      DIG_P2M: w_sum = i_a + {w_m_ext[AW-2:0], 1'b0};
      DIG_N2M: w_sum = i_a - {w_m_ext[AW-2:0], 1'b0};
      default: w_sum = i_a;
    endcase
    o_a  = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    o_q  = {w_sum[1:0], i_q[N-1:2]};
    o_q1 = i_q[1];
  end
`else
  // Add or subtract M per {Q[0],Q_1}, then arithmetic shift right by one.
  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_a + w_m_ext;
      2'b10:   w_sum = i_a - w_m_ext;
      default: w_sum = i_a;
    endcase
    o_a  = {w_sum[AW-1], w_sum[AW-1:1]};
    o_q  = {w_sum[0], i_q[N-1:1]};
    o_q1 = i_q[0];
  end
`endif

endmodule

// File: rtl/booth_multiplicador.sv
// booth_multiplicador: sequential signed Booth multiplier started by a rising
// edge of inicio. Holds the FSM, iteration counter, edge detect and outputs.
// BOOTH_RADIX4_EN selects the radix-4 datapath (N/2 iterations instead of N).
module booth_multiplicador
  import booth_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           Clk_100M,
  input  logic           reset,
  input  logic           inicio,
  input  logic [N-1:0]   multiplicador,
  input  logic [N-1:0]   multiplicando,
  output logic [2*N-1:0] producto,
  output logic           listo,
  output logic           ocupado
);

`ifdef BOOTH_RADIX4_EN
  localparam int AW   = N + 2;
  localparam int ITER = N / 2;
`else
  localparam int AW   = N + 1;
  localparam int ITER = N;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  estado_t        r_state;
  estado_t        w_state_next;
  logic           w_start;
  logic           r_inicio_d;
  logic [AW-1:0]  r_a;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_m;
  logic           r_q1;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_producto;
  logic           r_listo;
  logic [AW-1:0]  w_a_next;
  logic [N-1:0]   w_q_next;
  logic           w_q1_next;

  booth_paso #(
    .N  (N),
    .AW (AW)
  ) u_paso (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_next),
    .o_q  (w_q_next),
    .o_q1 (w_q1_next)
  );

  // FSM state register.
  always_ff @(posedge Clk_100M or posedge reset) begin
    if (reset) begin
      r_state <= INACTIVO;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a start is only a rising edge of inicio while idle.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      INACTIVO: begin
        if (inicio && !r_inicio_d) begin
          w_start      = 1'b1;
          w_state_next = OPERAR;
        end else begin
          w_state_next = INACTIVO;
        end
      end
      OPERAR: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = FIN;
        end else begin
          w_state_next = OPERAR;
        end
      end
      FIN:     w_state_next = INACTIVO;
      default: w_state_next = INACTIVO;
    endcase
  end

  // Edge detect, operand capture, iteration datapath and result registers.
  // inicio_d resets high so a button held through reset never starts.
  always_ff @(posedge Clk_100M or posedge reset) begin
    if (reset) begin
      r_inicio_d <= 1'b1;
      r_a        <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_q1       <= 1'b0;
      r_cnt      <= '0;
      r_producto <= '0;
      r_listo    <= 1'b0;
    end else begin
      r_inicio_d <= inicio;
      r_listo    <= 1'b0;
      if (w_start) begin
        r_m   <= multiplicando;
        r_q   <= multiplicador;
        r_a   <= '0;
        r_q1  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == OPERAR) begin
        r_a   <= w_a_next;
        r_q   <= w_q_next;
        r_q1  <= w_q1_next;
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
      if (r_state == FIN) begin
        r_producto <= {r_a[N-1:0], r_q};
        r_listo    <= 1'b1;
      end
    end
  end

  assign producto = r_producto;
  assign listo    = r_listo;
  assign ocupado  = (r_state != INACTIVO);

endmodule

// File: tb/tb_booth_multiplicador.sv
// Self-checking bench for booth_multiplicador: a cycle-level behavioural model
// (start edge -> fixed latency -> a*b) checked every cycle, plus directed cases.
module tb_booth_multiplicador;

  localparam int N = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 9;
`endif

  logic           Clk_100M;
  logic           reset;
  logic           inicio;
  logic [N-1:0]   multiplicador;
  logic [N-1:0]   multiplicando;
  logic [2*N-1:0] producto;
  logic           listo;
  logic           ocupado;

  booth_multiplicador #(.N(N)) dut (
    .Clk_100M      (Clk_100M),
    .reset         (reset),
    .inicio        (inicio),
    .multiplicador (multiplicador),
    .multiplicando (multiplicando),
    .producto      (producto),
    .listo         (listo),
    .ocupado       (ocupado)
  );

  initial Clk_100M = 1'b0;
  always #5 Clk_100M = ~Clk_100M;

  int n_tests = 0;
  int n_fail  = 0;
  int listo_cnt = 0;

  // Behavioural model state
  logic           m_prev;
  int             m_busy;
  logic [2*N-1:0] m_prod;
  logic           m_listo;
  logic [N-1:0]   m_a, m_b;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = 1'b1;
    m_busy  = 0;
    m_prod  = '0;
    m_listo = 1'b0;
  endtask

  task automatic model_step();
    int ia, ib;
    m_listo = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        ia = int'($signed(m_a));
        ib = int'($signed(m_b));
        m_prod  = 16'(ia * ib);
        m_listo = 1'b1;
      end
    end else if (inicio && !m_prev) begin
      m_a    = multiplicador;
      m_b    = multiplicando;
      m_busy = LAT;
    end
    m_prev = inicio;
  endtask

  task automatic compare_all();
    check("listo", 32'(listo), 32'(m_listo));
    check("ocupado", 32'(ocupado), 32'(m_busy > 0));
    check("producto", 32'(producto), 32'(m_prod));
  endtask

  // One clock: advance model on the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge Clk_100M);
    if (reset) model_reset();
    else model_step();
    #1;
    compare_all();
    if (listo) listo_cnt++;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
  endtask

  // Wait for listo with a cycle budget; returns cycles elapsed and ocupado-high count.
  task automatic wait_listo(output int n, output int busy_n);
    bit got;
    got = 1'b0;
    n = 0;
    busy_n = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (ocupado) busy_n++;
      if (listo) got = 1'b1;
    end
    check("listo_timeout", 32'(got), 32'd1);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                        output int n, output int busy_n);
    multiplicador = a;
    multiplicando = b;
    inicio = 1'b0;
    tick();
    inicio = 1'b1;
    wait_listo(n, busy_n);
    if (!hold) inicio = 1'b0;
  endtask

  initial begin
    int n, bn, lc;
    logic [2*N-1:0] saved;
    logic [N-1:0] corner [5];
    logic [N-1:0] ra, rb;
    corner[0] = 8'h80; corner[1] = 8'h7F; corner[2] = 8'hFF;
    corner[3] = 8'h00; corner[4] = 8'h01;

    reset = 1'b1;
    inicio = 1'b0;
    multiplicador = '0;
    multiplicando = '0;
    model_reset();
    #1;
    compare_all();
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic product and latency
    run_op(8'd3, 8'hFC, 1'b0, n, bn);
    check("basic_prod", 32'(producto), 32'h0000FFF4);
    check("basic_model", 32'(m_prod), 32'h0000FFF4);
    check("basic_latency", 32'(n), 32'(LAT + 1));
    check("basic_busy_cycles", 32'(bn), 32'(LAT));

    // Extreme cases
    run_op(8'h80, 8'h80, 1'b0, n, bn);
    check("min_x_min", 32'(producto), 32'h00004000);
    check("min_x_min_model", 32'(m_prod), 32'h00004000);
    run_op(8'h7F, 8'h80, 1'b0, n, bn);
    check("max_x_min", 32'(producto), 32'h0000C080);
    run_op(8'hFF, 8'hFF, 1'b0, n, bn);
    check("m1_x_m1", 32'(producto), 32'h00000001);
    run_op(8'h00, 8'hB3, 1'b0, n, bn);
    check("zero_x_m77", 32'(producto), 32'h00000000);

    // Held start: exactly one listo
    lc = listo_cnt;
    run_op(8'd5, 8'd6, 1'b1, n, bn);
    saved = producto;
    for (int i = 0; i < 1000; i++) tick();
    check("held_one_listo", 32'(listo_cnt - lc), 32'd1);
    check("held_prod", 32'(producto), 32'd30);
    check("held_saved", 32'(producto), 32'(saved));
    inicio = 1'b0;
    tick();

    // Start while busy is ignored
    multiplicador = 8'd3;
    multiplicando = 8'hFC;
    tick();
    inicio = 1'b1;
    tick(); tick(); tick();
    inicio = 1'b0;
    tick();
    multiplicador = 8'h55;
    multiplicando = 8'h11;
    inicio = 1'b1;
    wait_listo(n, bn);
    check("busy_ignore_prod", 32'(producto), 32'h0000FFF4);
    inicio = 1'b0;
    lc = listo_cnt;
    for (int i = 0; i < 15; i++) tick();
    check("busy_no_deferred", 32'(listo_cnt - lc), 32'd0);

    // Abort by reset mid-operation
    multiplicador = 8'd3;
    multiplicando = 8'hFC;
    tick();
    inicio = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    lc = listo_cnt;
    assert_reset();
    check("abort_prod", 32'(producto), 32'd0);
    check("abort_busy", 32'(ocupado), 32'd0);
    inicio = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("abort_no_listo", 32'(listo_cnt - lc), 32'd0);
    run_op(8'd7, 8'd9, 1'b0, n, bn);
    check("after_abort", 32'(producto), 32'h0000003F);

    // inicio held high across reset release: no start
    inicio = 1'b1;
    assert_reset();
    tick(); tick();
    reset = 1'b0;
    lc = listo_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("held_reset_no_start", 32'(listo_cnt - lc), 32'd0);
    inicio = 1'b0;
    tick();

    // Randomized operands with corner bias
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ra = corner[$urandom_range(0, 4)];
      else ra = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb = corner[$urandom_range(0, 4)];
      else rb = 8'($urandom);
      run_op(ra, rb, 1'b0, n, bn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
